// File: rtl/switch_debouncer_pkg.sv
// Shared defaults and parameter helpers for the switch debouncer.
package switch_debouncer_pkg;

   localparam int unsigned DefaultWidth      = 20;
   localparam int unsigned DefaultSyncStages = 2;
   localparam int unsigned MinSyncStages     = 2;

   // Fewer than two synchronizer flops gives no metastability margin; clamp upward.
   function automatic int unsigned legal_sync_stages(input int unsigned stages);
      return (stages < MinSyncStages) ? MinSyncStages : stages;
   endfunction

endpackage

// File: rtl/switch_debouncer_bit_synchronizer.sv
// Single-bit multi-flop synchronizer with asynchronous reset to a chosen level.
module bit_synchronizer #(
   parameter int unsigned Stages     = 2,
   parameter logic        ResetValue = 1'b0
) (
   input  logic Clock,
   input  logic Reset,
   input  logic d,
   output logic q
);

   logic [Stages-1:0] r_sync;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_sync <= {Stages{ResetValue}};
      end else begin
         r_sync <= {r_sync[Stages-2:0], d};
      end
   end

   assign q = r_sync[Stages-1];

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a noisy asynchronous switch: synchronizer plus saturating stability counter.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int unsigned Width      = DefaultWidth,
   parameter int unsigned SyncStages = DefaultSyncStages,
   parameter logic        ResetValue = 1'b0
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Enable,
   input  logic In,
   output logic Out
);

   localparam int unsigned    Stages  = legal_sync_stages(SyncStages);
   localparam logic [Width-1:0] TermCnt = '1;

   logic             w_s_last;
   logic [Width-1:0] r_cnt;
   logic             r_out;
   logic [Width-1:0] w_cnt_next;
   logic             w_out_next;

   bit_synchronizer #(
      .Stages     (Stages),
      .ResetValue (ResetValue)
   ) u_sync (
      .Clock (Clock),
      .Reset (Reset),
      .d     (In),
      .q     (w_s_last)
   );

   // Any return to the current level restarts the count; terminal count commits the new level.
   always_comb begin
      w_cnt_next = r_cnt;
      w_out_next = r_out;
      if (Enable) begin
         if (w_s_last == r_out) begin
            w_cnt_next = '0;
         end else if (r_cnt == TermCnt) begin
            w_out_next = w_s_last;
            w_cnt_next = '0;
         end else begin
            w_cnt_next = r_cnt + Width'(1);
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_cnt <= '0;
         r_out <= ResetValue;
      end else begin
         r_cnt <= w_cnt_next;
         r_out <= w_out_next;
      end
   end

   assign Out = r_out;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (Width=4, SyncStages=2, both reset values).
module tb_switch_debouncer;

   localparam int unsigned W   = 4;
   localparam int unsigned SS  = 2;
   localparam int          THR = 1 << W;

   logic Clock  = 1'b0;
   logic Reset  = 1'b1;
   logic Enable = 1'b1;
   logic In0    = 1'b1;
   logic In1    = 1'b1;
   logic Out0;
   logic Out1;

   int errors = 0;
   int checks = 0;

   always #5 Clock = ~Clock;

   switch_debouncer #(.Width(W), .SyncStages(SS), .ResetValue(1'b0)) dut0 (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .In(In0), .Out(Out0));

   switch_debouncer #(.Width(W), .SyncStages(SS), .ResetValue(1'b1)) dut1 (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .In(In1), .Out(Out1));

   // Reference: the input seen SS edges late must differ from Out on THR consecutive enabled edges.
   logic mq0[$];
   logic mq1[$];
   int   run0 = 0;
   int   run1 = 0;
   logic m_out0 = 1'b0;
   logic m_out1 = 1'b1;

   always @(posedge Clock or posedge Reset) begin : model
      logic s;
      if (Reset) begin
         mq0.delete();
         mq1.delete();
         for (int i = 0; i < SS; i++) begin
            mq0.push_back(1'b0);
            mq1.push_back(1'b1);
         end
         run0 = 0; run1 = 0;
         m_out0 = 1'b0; m_out1 = 1'b1;
      end else begin
         s = mq0.pop_front();
         mq0.push_back(In0);
         if (Enable) begin
            if (s == m_out0) run0 = 0;
            else begin
               run0++;
               if (run0 == THR) begin m_out0 = s; run0 = 0; end
            end
         end
         s = mq1.pop_front();
         mq1.push_back(In1);
         if (Enable) begin
            if (s == m_out1) run1 = 0;
            else begin
               run1++;
               if (run1 == THR) begin m_out1 = s; run1 = 0; end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance n cycles, comparing both outputs against the model at each falling edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clock);
         chk("model_out0", Out0, m_out0);
         chk("model_out1", Out1, m_out1);
      end
   endtask

   initial begin
      // Reset held with In high
      tick(5);
      chk("reset_out0", Out0, 1'b0);
      chk("reset_out1", Out1, 1'b1);
      In0 = 1'b0;
      Reset = 1'b0;
      tick(20);
      chk("idle_out0", Out0, 1'b0);

      // Clean rise then clean fall on dut0
      In0 = 1'b1;
      for (int e = 1; e <= 17; e++) begin tick(1); chk("rise_hold", Out0, 1'b0); end
      tick(1); chk("rise_edge18", Out0, 1'b1);
      tick(5);
      In0 = 1'b0;
      for (int e = 1; e <= 17; e++) begin tick(1); chk("fall_hold", Out0, 1'b1); end
      tick(1); chk("fall_edge18", Out0, 1'b0);
      tick(5);

      // Bounce rejection
      In0 = 1'b1;
      for (int e = 0; e < 10; e++) begin tick(1); chk("bounce_a", Out0, 1'b0); end
      In0 = 1'b0;
      for (int e = 0; e < 3; e++)  begin tick(1); chk("bounce_b", Out0, 1'b0); end
      In0 = 1'b1;
      for (int e = 0; e < 14; e++) begin tick(1); chk("bounce_c", Out0, 1'b0); end
      In0 = 1'b0;
      for (int e = 0; e < 10; e++) begin tick(1); chk("bounce_d", Out0, 1'b0); end
      In0 = 1'b1;
      for (int e = 1; e <= 17; e++) begin tick(1); chk("settle_hold", Out0, 1'b0); end
      tick(1); chk("settle_edge18", Out0, 1'b1);
      tick(2);
      In0 = 1'b0;
      tick(25);
      chk("back_low", Out0, 1'b0);

      // Enable gating
      Enable = 1'b0;
      In0 = 1'b1;
      for (int e = 0; e < 40; e++) begin tick(1); chk("gated", Out0, 1'b0); end
      Enable = 1'b1;
      for (int e = 1; e <= 15; e++) begin tick(1); chk("enable_hold", Out0, 1'b0); end
      tick(1); chk("enable_edge16", Out0, 1'b1);

      // Asynchronous reset between clock edges while Out0 is high
      @(negedge Clock);
      #2 Reset = 1'b1;
      #1 chk("async_out0", Out0, 1'b0);
      chk("async_out1", Out1, 1'b1);
      for (int e = 0; e < 3; e++) begin tick(1); chk("in_reset", Out0, 1'b0); end
      Reset = 1'b0;
      for (int e = 1; e <= 17; e++) begin tick(1); chk("post_rst_hold", Out0, 1'b0); end
      tick(1); chk("post_rst_edge18", Out0, 1'b1);

      // Reset pulse mid-count
      In0 = 1'b0;
      tick(25);
      In0 = 1'b1;
      tick(10);
      Reset = 1'b1;
      tick(1);
      chk("midcnt_rst", Out0, 1'b0);
      Reset = 1'b0;
      for (int e = 1; e <= 17; e++) begin tick(1); chk("midcnt_hold", Out0, 1'b0); end
      tick(1); chk("midcnt_edge18", Out0, 1'b1);

      // Randomized segments with occasional enable drops and reset pulses
      for (int seg = 0; seg < 150; seg++) begin
         In0 = 1'($urandom_range(0, 1));
         In1 = 1'($urandom_range(0, 1));
         Enable = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 19) == 0) begin
            Reset = 1'b1;
            tick(1);
            Reset = 1'b0;
         end
         tick(int'($urandom_range(1, 24)));
      end

      // ResetValue=1 instance: falls after 18 edges of a held low input
      Enable = 1'b1;
      In1 = 1'b1;
      Reset = 1'b1;
      tick(1);
      chk("rv1_reset", Out1, 1'b1);
      Reset = 1'b0;
      tick(3);
      In1 = 1'b0;
      for (int e = 1; e <= 17; e++) begin tick(1); chk("rv1_hold", Out1, 1'b1); end
      tick(1); chk("rv1_edge18", Out1, 1'b0);
      tick(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
